// File: rtl/neuron_mac_relu.sv
// neuron_mac_relu: sequential multiply-accumulate neuron with bias, ReLU and
// positive saturation. Four-stage pipeline: fetch, multiply, accumulate, output.
module neuron_mac_relu #(
    parameter int numWeight    = 30,
    parameter int addressWidth = $clog2(numWeight),
    parameter int dataWidth    = 16,
    parameter int fracBits     = 12,
    parameter logic signed [dataWidth-1:0] bias = '0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    x_valid,
    input  logic [dataWidth-1:0]    x_in,
    output logic                    w_ren,
    output logic [addressWidth-1:0] w_radd,
    input  logic [dataWidth-1:0]    w_data,
    output logic                    out_valid,
    output logic [dataWidth-1:0]    out
);

    localparam int unsigned PROD_W = 2 * dataWidth;
    localparam int unsigned ACC_W  = PROD_W + addressWidth;

    localparam logic [addressWidth-1:0] CNT_LAST = addressWidth'(numWeight - 1);
    localparam logic signed [ACC_W-1:0] BIAS_ACC = (ACC_W'(bias)) <<< fracBits;
    localparam logic [dataWidth-1:0]    OUT_MAX  = {1'b0, {(dataWidth-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] RES_MAX  = ACC_W'(OUT_MAX);

    logic                    accept_c;
    logic                    is_first_c;
    logic                    is_last_c;

    logic [addressWidth-1:0] in_cnt_q, in_cnt_d;

    // Stage 1: fetch cycle, activation waits for the memory read
    logic                    v1_q, v1_d;
    logic                    first1_q, first1_d;
    logic                    last1_q, last1_d;
    logic signed [dataWidth-1:0] x1_q, x1_d;

    // Stage 2: registered full-width product
    logic                    v2_q, v2_d;
    logic                    first2_q, first2_d;
    logic                    last2_q, last2_d;
    logic signed [PROD_W-1:0] prod2_q, prod2_d;

    // Stage 3: accumulator, done marks that acc holds a completed vector
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic                    done_q, done_d;

    // Stage 4: output
    logic signed [ACC_W-1:0] sum_c;
    logic signed [ACC_W-1:0] res_c;
    logic                    out_valid_q, out_valid_d;
    logic [dataWidth-1:0]    out_q, out_d;

    assign accept_c   = x_valid & ~rst;
    assign is_first_c = (in_cnt_q == '0);
    assign is_last_c  = (in_cnt_q == CNT_LAST);

    assign w_ren     = accept_c;
    assign w_radd    = rst ? '0 : in_cnt_q;
    assign out_valid = out_valid_q;
    assign out       = out_q;

    // Next-state for counter, pipeline stages, accumulator and output
    always_comb begin
        in_cnt_d    = in_cnt_q;
        v1_d        = accept_c;
        first1_d    = is_first_c;
        last1_d     = is_last_c;
        x1_d        = x_in;
        v2_d        = v1_q;
        first2_d    = first1_q;
        last2_d     = last1_q;
        prod2_d     = PROD_W'(x1_q) * PROD_W'($signed(w_data));
        acc_d       = acc_q;
        done_d      = v2_q & last2_q;
        sum_c       = acc_q + BIAS_ACC;
        res_c       = sum_c >>> fracBits;
        out_valid_d = done_q;
        out_d       = out_q;

        if (accept_c) begin
            in_cnt_d = is_last_c ? '0 : in_cnt_q + addressWidth'(1);
        end

        if (v2_q) begin
            acc_d = first2_q ? ACC_W'(prod2_q) : acc_q + ACC_W'(prod2_q);
        end

        if (done_q) begin
            if (res_c[ACC_W-1]) begin
                out_d = '0;
            end else if (res_c > RES_MAX) begin
                out_d = OUT_MAX;
            end else begin
                out_d = res_c[dataWidth-1:0];
            end
        end
    end

    // Control state and accumulator, cleared by synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            in_cnt_q    <= '0;
            v1_q        <= 1'b0;
            v2_q        <= 1'b0;
            done_q      <= 1'b0;
            acc_q       <= '0;
            out_valid_q <= 1'b0;
            out_q       <= '0;
        end else begin
            in_cnt_q    <= in_cnt_d;
            v1_q        <= v1_d;
            v2_q        <= v2_d;
            done_q      <= done_d;
            acc_q       <= acc_d;
            out_valid_q <= out_valid_d;
            out_q       <= out_d;
        end
    end

    // Data-only pipeline registers, qualified by the valid bits
    always_ff @(posedge clk) begin
        first1_q <= first1_d;
        last1_q  <= last1_d;
        x1_q     <= x1_d;
        first2_q <= first2_d;
        last2_q  <= last2_d;
        prod2_q  <= prod2_d;
    end

endmodule

// File: tb/tb_neuron_mac_relu.sv
// Bench for neuron_mac_relu: two instances (bias 0 and bias 0.5) share one
// activation stream and weight table, checked against a per-vector model.
module tb_neuron_mac_relu;

    localparam int N = 30;

    logic        clk;
    logic        rst;
    logic        x_valid;
    logic [15:0] x_in;

    logic        w_ren0, w_ren1;
    logic [4:0]  w_radd0, w_radd1;
    logic [15:0] w_data0, w_data1;
    logic        out_valid0, out_valid1;
    logic [15:0] out0, out1;

    logic [15:0] wmem [N];

    neuron_mac_relu #(.numWeight(N), .dataWidth(16), .fracBits(12), .bias(16'sh0000)) dut0 (
        .clk(clk), .rst(rst), .x_valid(x_valid), .x_in(x_in),
        .w_ren(w_ren0), .w_radd(w_radd0), .w_data(w_data0),
        .out_valid(out_valid0), .out(out0)
    );

    neuron_mac_relu #(.numWeight(N), .dataWidth(16), .fracBits(12), .bias(16'sh0800)) dut1 (
        .clk(clk), .rst(rst), .x_valid(x_valid), .x_in(x_in),
        .w_ren(w_ren1), .w_radd(w_radd1), .w_data(w_data1),
        .out_valid(out_valid1), .out(out1)
    );

    // Weight memories with one-cycle registered read
    always @(posedge clk) begin
        if (w_ren0) w_data0 <= wmem[w_radd0];
        if (w_ren1) w_data1 <= wmem[w_radd1];
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    typedef struct {
        int          due;
        logic [15:0] o0;
        logic [15:0] o1;
    } exp_t;

    exp_t        pq[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          m_cnt = 0;
    longint      m_acc = 0;
    logic        e_v = 1'b0;
    logic [15:0] e_o0 = 16'h0;
    logic [15:0] e_o1 = 16'h0;
    int          pulses = 0;

    // Neuron result from the exact dot product: add bias, floor-shift, clamp
    function automatic logic [15:0] neuron(input longint dot, input logic [15:0] b);
        longint s;
        longint r;
        s = dot + (longint'($signed(b)) * 4096);
        r = s >>> 12;
        if (r < 0) return 16'h0000;
        if (r > 32767) return 16'h7FFF;
        return 16'(r);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // One clock cycle: drive inputs, check memory interface, advance model, check outputs
    task automatic step(input logic xv, input logic [15:0] xi, input logic r);
        rst     = r;
        x_valid = xv;
        x_in    = xi;
        #1;
        chk("w_ren0", 32'(w_ren0), 32'(xv & ~r));
        chk("w_ren1", 32'(w_ren1), 32'(xv & ~r));
        if (xv || r) chk("w_radd", 32'(w_radd0), r ? 32'd0 : 32'(m_cnt));
        @(posedge clk);
        cyc++;
        if (r) begin
            m_cnt = 0;
            pq.delete();
            e_v  = 1'b0;
            e_o0 = 16'h0;
            e_o1 = 16'h0;
        end else begin
            if (xv) begin
                if (m_cnt == 0) m_acc = 0;
                m_acc += longint'($signed(xi)) * longint'($signed(wmem[m_cnt]));
                if (m_cnt == N - 1) begin
                    pq.push_back('{cyc + 3, neuron(m_acc, 16'h0000), neuron(m_acc, 16'h0800)});
                    m_cnt = 0;
                end else begin
                    m_cnt++;
                end
            end
            e_v = 1'b0;
            if (pq.size() > 0 && pq[0].due == cyc) begin
                e_v  = 1'b1;
                e_o0 = pq[0].o0;
                e_o1 = pq[0].o1;
                pq.delete(0);
            end
        end
        #1;
        chk("out_valid0", 32'(out_valid0), 32'(e_v));
        chk("out_valid1", 32'(out_valid1), 32'(e_v));
        chk("out0", 32'(out0), 32'(e_o0));
        chk("out1", 32'(out1), 32'(e_o1));
        if (out_valid0) pulses++;
    endtask

    task automatic fill(input logic [15:0] w);
        for (int i = 0; i < N; i++) wmem[i] = w;
    endtask

    function automatic logic [15:0] rnd(input int span);
        return 16'($urandom_range(0, 2 * span - 1)) - 16'(span);
    endfunction

    initial begin
        rst     = 1'b1;
        x_valid = 1'b0;
        x_in    = 16'h0;
        fill(16'h0100);

        // Reset held three cycles with x_valid toggling, then idle: no pulse
        for (int i = 0; i < 3; i++) step(1'(i % 2), 16'h1000, 1'b1);
        for (int i = 0; i < 8; i++) step(1'b0, 16'h0, 1'b0);
        chk("reset_pulses", 32'(pulses), 32'd0);
        chk("reset_out", 32'(out0), 32'h0);

        // Basic sum: 30 x 1.0 * 1/16
        pulses = 0;
        for (int i = 0; i < N; i++) step(1'b1, 16'h1000, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, 16'h0, 1'b0);
        chk("basic_pulses", 32'(pulses), 32'd1);
        chk("basic_out", 32'(out0), 32'h1E00);
        chk("bias_out", 32'(out1), 32'h2600);

        // Saturation: 30 x 1.0 * 0.5 = 15.0
        pulses = 0;
        fill(16'h0800);
        for (int i = 0; i < N; i++) step(1'b1, 16'h1000, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, 16'h0, 1'b0);
        chk("sat_pulses", 32'(pulses), 32'd1);
        chk("sat_out", 32'(out0), 32'h7FFF);

        // ReLU: negative sum clamps to zero and still pulses
        pulses = 0;
        fill(16'hF000);
        for (int i = 0; i < N; i++) step(1'b1, 16'h1000, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, 16'h0, 1'b0);
        chk("relu_pulses", 32'(pulses), 32'd1);
        chk("relu_out", 32'(out0), 32'h0000);
        chk("relu_out_bias", 32'(out1), 32'h0000);

        // Three vectors: random gaps in the first, back-to-back after
        pulses = 0;
        for (int i = 0; i < N; i++) wmem[i] = rnd(16'h0400);
        for (int n = 0; n < N;) begin
            if ($urandom_range(0, 2) == 0) begin
                step(1'b0, rnd(16'h2000), 1'b0);
            end else begin
                step(1'b1, rnd(16'h2000), 1'b0);
                n++;
            end
        end
        for (int i = 0; i < 2 * N; i++) step(1'b1, rnd(16'h2000), 1'b0);
        for (int i = 0; i < 6; i++) step(1'b0, 16'h0, 1'b0);
        chk("b2b_pulses", 32'(pulses), 32'd3);

        // Mid-vector reset: partial vector discarded, next vector starts at index 0
        pulses = 0;
        fill(16'h0100);
        for (int i = 0; i < 10; i++) step(1'b1, 16'h1000, 1'b0);
        step(1'b0, 16'h0, 1'b1);
        for (int i = 0; i < N; i++) step(1'b1, 16'h1000, 1'b0);
        for (int i = 0; i < 6; i++) step(1'b0, 16'h0, 1'b0);
        chk("midrst_pulses", 32'(pulses), 32'd1);
        chk("midrst_out", 32'(out0), 32'h1E00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
